demux1to3_buf: RTL and testbench

Buffered 1-to-3 demultiplexer: the inverse of the team's 3-to-1 mux. A single valid/ready input stream is steered by `sel` to one of three output channels (a, b, c). Each channel has a one-entry output register. Words sent with the unused select code 2'b11 are discarded. The block sits where one producer feeds three independent consumers, and each consumer may stall on its own.

---
 rtl/demux1to3_pkg.sv | 12 +
 rtl/demux_slot.sv | 42 ++++
 rtl/demux1to3_buf.sv | 82 ++++++++
 tb/tb_demux1to3_buf.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/demux1to3_pkg.sv
// Shared select encoding and default widths for the buffered 1-to-3 demux.
package demux1to3_pkg;
  localparam int WIDTH_DEF = 8;
  localparam int CNT_W_DEF = 8;

  typedef enum logic [1:0] {
    SEL_A    = 2'b00,
    SEL_B    = 2'b01,
    SEL_C    = 2'b10,
    SEL_DROP = 2'b11
  } sel_e;
endpackage

// File: rtl/demux_slot.sv
// One-entry output buffer: load visible the cycle after the edge; can_load stays
// high while full if the consumer drains in the same cycle (no bubble).
module demux_slot #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             can_load
);
  logic             full_q, full_d;
  logic [WIDTH-1:0] data_q, data_d;

  always_comb begin
    full_d = full_q;
    data_d = data_q;
    if (full_q && out_ready) full_d = 1'b0;
    // A load overrides a simultaneous drain so the slot stays occupied.
    if (load) begin
      full_d = 1'b1;
      data_d = load_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full_q <= 1'b0;
      data_q <= '0;
    end else begin
      full_q <= full_d;
      data_q <= data_d;
    end
  end

  assign out_valid = full_q;
  assign out_data  = data_q;
  assign can_load  = ~full_q | out_ready;
endmodule

// File: rtl/demux1to3_buf.sv
// Steers one valid/ready stream to three 1-entry buffered channels; sel 11 drops.
// Optional saturating drop counter enabled by DEMUX1TO3_DROP_CNT_EN.
module demux1to3_buf
  import demux1to3_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
`ifdef DEMUX1TO3_DROP_CNT_EN
  , parameter int CNT_W = CNT_W_DEF
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       sel,
  output logic             in_ready,
  output logic             out_valid_a,
  output logic [WIDTH-1:0] out_data_a,
  input  logic             out_ready_a,
  output logic             out_valid_b,
  output logic [WIDTH-1:0] out_data_b,
  input  logic             out_ready_b,
  output logic             out_valid_c,
  output logic [WIDTH-1:0] out_data_c,
  input  logic             out_ready_c
`ifdef DEMUX1TO3_DROP_CNT_EN
  , output logic [CNT_W-1:0] drop_count
`endif
);
  logic can_load_a, can_load_b, can_load_c;
  logic load_a, load_b, load_c;

  // in_ready depends only on sel and the selected slot, never on in_valid.
  always_comb begin
    in_ready = 1'b1;
    case (sel)
      SEL_A:   in_ready = can_load_a;
      SEL_B:   in_ready = can_load_b;
      SEL_C:   in_ready = can_load_c;
      default: in_ready = 1'b1;
    endcase
  end

  assign load_a = in_valid && (sel == SEL_A) && can_load_a;
  assign load_b = in_valid && (sel == SEL_B) && can_load_b;
  assign load_c = in_valid && (sel == SEL_C) && can_load_c;

  demux_slot #(.WIDTH(WIDTH)) u_slot_a (
    .clk(clk), .rst(rst), .load(load_a), .load_data(in_data),
    .out_ready(out_ready_a), .out_valid(out_valid_a), .out_data(out_data_a),
    .can_load(can_load_a)
  );

  demux_slot #(.WIDTH(WIDTH)) u_slot_b (
    .clk(clk), .rst(rst), .load(load_b), .load_data(in_data),
    .out_ready(out_ready_b), .out_valid(out_valid_b), .out_data(out_data_b),
    .can_load(can_load_b)
  );

  demux_slot #(.WIDTH(WIDTH)) u_slot_c (
    .clk(clk), .rst(rst), .load(load_c), .load_data(in_data),
    .out_ready(out_ready_c), .out_valid(out_valid_c), .out_data(out_data_c),
    .can_load(can_load_c)
  );

`ifdef DEMUX1TO3_DROP_CNT_EN
  logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (in_valid && (sel == SEL_DROP) && (drop_cnt_q != {CNT_W{1'b1}}))
      drop_cnt_d = drop_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) drop_cnt_q <= '0;
    else     drop_cnt_q <= drop_cnt_d;
  end

  assign drop_count = drop_cnt_q;
`endif
endmodule

// File: tb/tb_demux1to3_buf.sv
// Directed plus random bench for demux1to3_buf against a queue-based channel model.
module tb_demux1to3_buf;
  localparam int W = 8;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic [W-1:0] in_data;
  logic [1:0]   sel;
  logic         in_ready;
  logic [2:0]   ordy;
  logic [2:0]   vld;
  logic [W-1:0] dat [3];

  int total = 0;
  int bad   = 0;
  int drop_exp = 0;
  int sat_exp  = 0;
  int drained [3];
  logic [W-1:0] mq [3][$];

`ifdef DEMUX1TO3_DROP_CNT_EN
  logic [7:0] drop_count;
  logic [1:0] sat_count;
  logic       s_rdy;
  logic [2:0] s_vld;
  logic [W-1:0] s_dat [3];
`endif

  demux1to3_buf #(
    .WIDTH(W)
`ifdef DEMUX1TO3_DROP_CNT_EN
    , .CNT_W(8)
`endif
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .sel(sel),
    .in_ready(in_ready),
    .out_valid_a(vld[0]), .out_data_a(dat[0]), .out_ready_a(ordy[0]),
    .out_valid_b(vld[1]), .out_data_b(dat[1]), .out_ready_b(ordy[1]),
    .out_valid_c(vld[2]), .out_data_c(dat[2]), .out_ready_c(ordy[2])
`ifdef DEMUX1TO3_DROP_CNT_EN
    , .drop_count(drop_count)
`endif
  );

`ifdef DEMUX1TO3_DROP_CNT_EN
  demux1to3_buf #(.WIDTH(W), .CNT_W(2)) u_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .sel(sel),
    .in_ready(s_rdy),
    .out_valid_a(s_vld[0]), .out_data_a(s_dat[0]), .out_ready_a(ordy[0]),
    .out_valid_b(s_vld[1]), .out_data_b(s_dat[1]), .out_ready_b(ordy[1]),
    .out_valid_c(s_vld[2]), .out_data_c(s_dat[2]), .out_ready_c(ordy[2]),
    .drop_count(sat_count)
  );
`endif

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: compare at negedge against the model, then advance the model at posedge.
  task automatic step();
    logic exp_rdy;
    int   s;
    @(negedge clk);
    s = int'(sel);
    exp_rdy = (s == 3) ? 1'b1 : ((mq[s].size() == 0) || ordy[s]);
    chk("in_ready", {31'd0, in_ready}, {31'd0, exp_rdy});
    for (int c = 0; c < 3; c++) begin
      chk($sformatf("valid_%0d", c), {31'd0, vld[c]}, {31'd0, mq[c].size() != 0});
      if (mq[c].size() != 0)
        chk($sformatf("data_%0d", c), {24'd0, dat[c]}, {24'd0, mq[c][0]});
    end
`ifdef DEMUX1TO3_DROP_CNT_EN
    chk("drop_count", {24'd0, drop_count}, drop_exp);
    chk("sat_count", {30'd0, sat_count}, sat_exp);
`endif
    @(posedge clk);
    for (int c = 0; c < 3; c++) begin
      if (mq[c].size() != 0 && ordy[c]) begin
        void'(mq[c].pop_front());
        drained[c]++;
      end
    end
    if (in_valid && exp_rdy) begin
      if (s == 3) begin
        if (drop_exp < 255) drop_exp++;
        if (sat_exp < 3) sat_exp++;
      end else begin
        mq[s].push_back(in_data);
      end
    end
    #1;
  endtask

  task automatic send(input logic [1:0] s, input logic [W-1:0] d);
    in_valid = 1'b1;
    sel      = s;
    in_data  = d;
    step();
  endtask

  task automatic clear_model();
    for (int c = 0; c < 3; c++) mq[c].delete();
    drop_exp = 0;
    sat_exp  = 0;
  endtask

  // Called just after reset release with inputs set: the first edge must accept.
  task automatic first_accept(input int c, input logic [W-1:0] d);
    @(posedge clk);
    #1;
    chk("first_valid", {31'd0, vld[c]}, 32'd1);
    chk("first_data", {24'd0, dat[c]}, {24'd0, d});
    mq[c].push_back(d);
    in_valid = 1'b0;
  endtask

  initial begin
    int b0, c0;
    for (int c = 0; c < 3; c++) drained[c] = 0;
    rst = 1'b1; in_valid = 1'b1; sel = 2'b00; in_data = 8'h77; ordy = 3'b111;
    #1;
    for (int c = 0; c < 3; c++) begin
      chk("rst_valid", {31'd0, vld[c]}, 32'd0);
      chk("rst_data", {24'd0, dat[c]}, 32'd0);
    end
    #2 rst = 1'b0;
    first_accept(0, 8'h77);

    // Routing
    send(2'b00, 8'hA5);
    chk("route_a", {24'd0, dat[0]}, 32'hA5);
    chk("route_b_idle", {31'd0, vld[1]}, 32'd0);
    send(2'b01, 8'h3C);
    chk("route_b", {24'd0, dat[1]}, 32'h3C);
    chk("route_a_gone", {31'd0, vld[0]}, 32'd0);
    send(2'b10, 8'hF0);
    chk("route_c", {24'd0, dat[2]}, 32'hF0);
    chk("route_b_gone", {31'd0, vld[1]}, 32'd0);
    in_valid = 1'b0;
    step();

    // Backpressure
    ordy = 3'b110;
    send(2'b00, 8'h11);
    in_data = 8'h22;
    #1 chk("bp_rdy_low", {31'd0, in_ready}, 32'd0);
    step();
    sel = 2'b01;
    #1 chk("bp_rdy_high", {31'd0, in_ready}, 32'd1);
    step();
    chk("bp_b_data", {24'd0, dat[1]}, 32'h22);
    chk("bp_a_held", {24'd0, dat[0]}, 32'h11);
    in_valid = 1'b0;
    ordy = 3'b111;
    step();
    chk("bp_a_drained", {31'd0, vld[0]}, 32'd0);

    // Same-cycle drain and fill
    ordy = 3'b110;
    send(2'b00, 8'h55);
    ordy = 3'b111;
    send(2'b00, 8'h66);
    chk("fill_valid", {31'd0, vld[0]}, 32'd1);
    chk("fill_data", {24'd0, dat[0]}, 32'h66);
    in_valid = 1'b0;
    step();

    // Drops
    for (int i = 0; i < 3; i++) send(2'b11, 8'(i));
    chk("drop_no_valid", {29'd0, vld}, 32'd0);
`ifdef DEMUX1TO3_DROP_CNT_EN
    chk("drop_count3", {24'd0, drop_count}, 32'd3);
    send(2'b11, 8'h04);
    send(2'b11, 8'h05);
    chk("drop_sat", {30'd0, sat_count}, 32'd3);
    chk("drop_count5", {24'd0, drop_count}, 32'd5);
`endif

    // Independent stall: a held, b and c alternate
    ordy = 3'b110;
    send(2'b00, 8'hAA);
    b0 = drained[1];
    c0 = drained[2];
    for (int i = 0; i < 20; i++) send((i % 2) ? 2'b10 : 2'b01, 8'(8'h40 + i));
    in_valid = 1'b0;
    step();
    chk("stall_a_held", {24'd0, dat[0]}, 32'hAA);
    chk("stall_b_count", drained[1] - b0, 32'd10);
    chk("stall_c_count", drained[2] - c0, 32'd10);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      in_valid = 1'($urandom_range(0, 1));
      sel      = 2'($urandom_range(0, 3));
      in_data  = 8'($urandom);
      ordy     = 3'($urandom_range(0, 7));
      step();
    end

    // Asynchronous reset mid-transfer with all slots full
    ordy = 3'b000;
    send(2'b00, 8'h01);
    send(2'b01, 8'h02);
    send(2'b10, 8'h03);
    send(2'b11, 8'h04);
    in_valid = 1'b0;
    chk("pre_rst_full", {29'd0, vld}, 32'd7);
    #2 rst = 1'b1;
    #1;
    for (int c = 0; c < 3; c++) begin
      chk("arst_valid", {31'd0, vld[c]}, 32'd0);
      chk("arst_data", {24'd0, dat[c]}, 32'd0);
    end
`ifdef DEMUX1TO3_DROP_CNT_EN
    chk("arst_drop", {24'd0, drop_count}, 32'd0);
`endif
    clear_model();
    #2 rst = 1'b0;
    ordy = 3'b111; in_valid = 1'b1; sel = 2'b01; in_data = 8'h99;
    first_accept(1, 8'h99);
    for (int i = 0; i < 3; i++) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
